change_dispenser: RTL and testbench

Change-return sequencer for the coin vending controller. On a request it latches a BCD change amount (the same tens/units digits the vending core drives to the display) and ejects it as timed pulses to a 10-coin and a 5-coin ejector, largest coin first. It sits directly downstream of the vending core's change/amount outputs and upstream of the physical ejector drivers and the seg7 display digits.

---
 rtl/change_dispenser_if.sv | 23 ++
 rtl/change_dispenser.sv | 148 ++++++++++++++
 tb/tb_change_dispenser.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Handshake bundle between the vending core (master) and the change dispenser (slave).
interface change_dispenser_if;
    logic       start;
    logic [3:0] amt_ten;
    logic [3:0] amt_single;
    logic       busy;
    logic       coin10_out;
    logic       coin5_out;
    logic       done;
    logic       err;
    logic [3:0] rem_ten;
    logic [3:0] rem_single;

    modport master (
        output start, amt_ten, amt_single,
        input  busy, coin10_out, coin5_out, done, err, rem_ten, rem_single
    );

    modport slave (
        input  start, amt_ten, amt_single,
        output busy, coin10_out, coin5_out, done, err, rem_ten, rem_single
    );
endinterface

// File: rtl/change_dispenser.sv
// Change-return sequencer: latches a BCD change amount and ejects it as timed
// 10-coin / 5-coin pulses, largest coin first.
module change_dispenser #(
    parameter int PULSE_W = 25000000,
    parameter int GAP_W   = 12500000
) (
    input  logic ck,
    input  logic reset,
    change_dispenser_if.slave bus
);

    localparam int unsigned MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int unsigned CNT_W = $clog2(MAX_W) + 1;
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        FIN
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       rem_ten_q, rem_ten_n;
    logic [3:0]       rem_single_q, rem_single_n;
    logic             coin10_q, coin10_n;
    logic             coin5_q, coin5_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             err_q, err_n;
    logic             req_invalid;
    logic             req_zero;

    assign req_invalid = (bus.amt_ten > 4'd9) ||
                         !((bus.amt_single == 4'd0) || (bus.amt_single == 4'd5));
    assign req_zero    = (bus.amt_ten == 4'd0) && (bus.amt_single == 4'd0);

    always_ff @(posedge ck) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rem_ten_q    <= '0;
            rem_single_q <= '0;
            coin10_q     <= 1'b0;
            coin5_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            rem_ten_q    <= rem_ten_n;
            rem_single_q <= rem_single_n;
            coin10_q     <= coin10_n;
            coin5_q      <= coin5_n;
            busy_q       <= busy_n;
            done_q       <= done_n;
            err_q        <= err_n;
        end
    end

    // Outputs are registered, so every output value here is the one for the next cycle.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        rem_ten_n    = rem_ten_q;
        rem_single_n = rem_single_q;
        coin10_n     = coin10_q;
        coin5_n      = coin5_q;
        busy_n       = busy_q;
        done_n       = 1'b0;
        err_n        = 1'b0;

        unique case (state)
            IDLE: begin
                coin10_n = 1'b0;
                coin5_n  = 1'b0;
                busy_n   = 1'b0;
                if (bus.start) begin
                    if (req_invalid) begin
                        err_n = 1'b1;
                    end else if (req_zero) begin
                        rem_ten_n    = '0;
                        rem_single_n = '0;
                        done_n       = 1'b1;
                        state_n      = FIN;
                    end else begin
                        rem_ten_n    = bus.amt_ten;
                        rem_single_n = bus.amt_single;
                        busy_n       = 1'b1;
                        cnt_n        = PULSE_LD;
                        coin10_n     = (bus.amt_ten != 4'd0);
                        coin5_n      = (bus.amt_ten == 4'd0);
                        state_n      = PULSE;
                    end
                end
            end

            PULSE: begin
                if (cnt == '0) begin
                    if (coin10_q) rem_ten_n = rem_ten_q - 4'd1;
                    else          rem_single_n = 4'd0;
                    coin10_n = 1'b0;
                    coin5_n  = 1'b0;
                    cnt_n    = GAP_LD;
                    state_n  = GAP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            GAP: begin
                if (cnt == '0) begin
                    if ((rem_ten_q != 4'd0) || (rem_single_q != 4'd0)) begin
                        coin10_n = (rem_ten_q != 4'd0);
                        coin5_n  = (rem_ten_q == 4'd0);
                        cnt_n    = PULSE_LD;
                        state_n  = PULSE;
                    end else begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = FIN;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            FIN: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

    assign bus.busy       = busy_q;
    assign bus.coin10_out = coin10_q;
    assign bus.coin5_out  = coin5_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.rem_ten    = rem_ten_q;
    assign bus.rem_single = rem_single_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with PULSE_W=4, GAP_W=2: a vector table of
// single requests plus hand-written multi-cycle sequences.
module tb_change_dispenser;

    logic ck;
    logic reset;

    change_dispenser_if bus ();

    change_dispenser #(
        .PULSE_W(4),
        .GAP_W  (2)
    ) dut (
        .ck   (ck),
        .reset(reset),
        .bus  (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int n_pass  = 0;
    int n_total = 0;

    logic       tr_c10  [0:127];
    logic       tr_c5   [0:127];
    logic       tr_busy [0:127];
    logic       tr_done [0:127];
    logic       tr_err  [0:127];
    logic [3:0] tr_rt   [0:127];
    logic [3:0] tr_rs   [0:127];

    int n10, n5, busy_cnt, done_cnt, err_cnt, first_done, first_err, first_coin;

    typedef struct {
        logic [3:0] ten;
        logic [3:0] single;
        int         exp_err_at;
        int         exp_done_at;
        int         exp_n10;
        int         exp_n5;
        int         exp_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic record(input int k);
        tr_c10[k]  = bus.coin10_out;
        tr_c5[k]   = bus.coin5_out;
        tr_busy[k] = bus.busy;
        tr_done[k] = bus.done;
        tr_err[k]  = bus.err;
        tr_rt[k]   = bus.rem_ten;
        tr_rs[k]   = bus.rem_single;
    endtask

    // Start sampled at the next edge; afterwards the bench sits in cycle t+1.
    task automatic issue(input logic [3:0] ten, input logic [3:0] single);
        record(0);
        bus.amt_ten    = ten;
        bus.amt_single = single;
        bus.start      = 1'b1;
        @(posedge ck); #1;
        bus.start      = 1'b0;
        bus.amt_ten    = 4'd7;
        bus.amt_single = 4'd5;
    endtask

    task automatic capture(input int n, input int inj_at, input logic [3:0] it,
                           input logic [3:0] is, input int rst_at);
        for (int k = 1; k <= n; k++) begin
            record(k);
            if (k == inj_at) begin
                bus.amt_ten    = it;
                bus.amt_single = is;
                bus.start      = 1'b1;
            end
            if (k == rst_at) reset = 1'b0;
            @(posedge ck); #1;
            bus.start = 1'b0;
            reset     = 1'b1;
        end
    endtask

    task automatic analyze(input int n);
        n10 = 0; n5 = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0;
        first_done = 0; first_err = 0; first_coin = 0;
        for (int k = 1; k <= n; k++) begin
            if (tr_c10[k] && !tr_c10[k-1]) n10++;
            if (tr_c5[k] && !tr_c5[k-1]) n5++;
            if ((tr_c10[k] || tr_c5[k]) && first_coin == 0) first_coin = k;
            if (tr_busy[k]) busy_cnt++;
            if (tr_done[k]) begin
                done_cnt++;
                if (first_done == 0) first_done = k;
            end
            if (tr_err[k]) begin
                err_cnt++;
                if (first_err == 0) first_err = k;
            end
        end
    endtask

    initial begin
        vecs[0] = '{4'd2,  4'd5, 0, 19, 2, 1, 18};
        vecs[1] = '{4'd0,  4'd0, 0,  1, 0, 0,  0};
        vecs[2] = '{4'd0,  4'd3, 1,  0, 0, 0,  0};
        vecs[3] = '{4'd10, 4'd0, 1,  0, 0, 0,  0};
        vecs[4] = '{4'd9,  4'd5, 0, 61, 9, 1, 60};
        vecs[5] = '{4'd0,  4'd5, 0,  7, 0, 1,  6};
        vecs[6] = '{4'd1,  4'd0, 0,  7, 1, 0,  6};
        vecs[7] = '{4'd9,  4'd6, 1,  0, 0, 0,  0};
        vecs[8] = '{4'd15, 4'd5, 1,  0, 0, 0,  0};
        vecs[9] = '{4'd9,  4'd0, 0, 55, 9, 0, 54};

        reset = 1'b0;
        bus.start = 1'b0;
        bus.amt_ten = 4'd0;
        bus.amt_single = 4'd0;
        repeat (3) @(posedge ck);
        #1;
        check("rst_busy",   int'(bus.busy), 0);
        check("rst_coin10", int'(bus.coin10_out), 0);
        check("rst_coin5",  int'(bus.coin5_out), 0);
        check("rst_done",   int'(bus.done), 0);
        check("rst_err",    int'(bus.err), 0);
        check("rst_rem",    int'({bus.rem_ten, bus.rem_single}), 0);
        reset = 1'b1;
        @(posedge ck); #1;

        for (int v = 0; v < 10; v++) begin
            issue(vecs[v].ten, vecs[v].single);
            capture(70, 0, 4'd0, 4'd0, 0);
            analyze(70);
            check($sformatf("v%0d_err_at", v),  first_err,  vecs[v].exp_err_at);
            check($sformatf("v%0d_err_cnt", v), err_cnt,    (vecs[v].exp_err_at != 0) ? 1 : 0);
            check($sformatf("v%0d_done_at", v), first_done, vecs[v].exp_done_at);
            check($sformatf("v%0d_done_cnt", v), done_cnt,  (vecs[v].exp_done_at != 0) ? 1 : 0);
            check($sformatf("v%0d_n10", v),     n10,        vecs[v].exp_n10);
            check($sformatf("v%0d_n5", v),      n5,         vecs[v].exp_n5);
            check($sformatf("v%0d_busy", v),    busy_cnt,   vecs[v].exp_busy);
            check($sformatf("v%0d_first_coin", v), first_coin,
                  (vecs[v].exp_n10 + vecs[v].exp_n5 != 0) ? 1 : 0);
            check($sformatf("v%0d_rem_end", v), int'({tr_rt[70], tr_rs[70]}), 0);
        end

        // Amount 25, cycle by cycle.
        issue(4'd2, 4'd5);
        capture(22, 0, 4'd0, 4'd0, 0);
        for (int k = 1; k <= 21; k++) begin
            check($sformatf("a25_c10@%0d", k), int'(tr_c10[k]),
                  ((k >= 1 && k <= 4) || (k >= 7 && k <= 10)) ? 1 : 0);
            check($sformatf("a25_c5@%0d", k), int'(tr_c5[k]), (k >= 13 && k <= 16) ? 1 : 0);
            check($sformatf("a25_busy@%0d", k), int'(tr_busy[k]), (k >= 1 && k <= 18) ? 1 : 0);
            check($sformatf("a25_done@%0d", k), int'(tr_done[k]), (k == 19) ? 1 : 0);
        end
        check("a25_rem@1",  int'({tr_rt[1],  tr_rs[1]}),  8'h25);
        check("a25_rem@4",  int'({tr_rt[4],  tr_rs[4]}),  8'h25);
        check("a25_rem@5",  int'({tr_rt[5],  tr_rs[5]}),  8'h15);
        check("a25_rem@11", int'({tr_rt[11], tr_rs[11]}), 8'h05);
        check("a25_rem@17", int'({tr_rt[17], tr_rs[17]}), 8'h00);

        // Amount 90 with a second start (05) at t+20 that must be ignored.
        issue(4'd9, 4'd0);
        capture(70, 20, 4'd0, 4'd5, 0);
        analyze(70);
        check("a90_n10",      n10, 9);
        check("a90_n5",       n5, 0);
        check("a90_done_at",  first_done, 55);
        check("a90_done_cnt", done_cnt, 1);
        check("a90_busy",     busy_cnt, 54);

        // Amount 20 with reset at t+3, then a fresh 05.
        issue(4'd2, 4'd0);
        capture(40, 0, 4'd0, 4'd0, 3);
        analyze(40);
        check("rst_mid_c10@4",  int'(tr_c10[4]), 0);
        check("rst_mid_c5@4",   int'(tr_c5[4]), 0);
        check("rst_mid_busy@4", int'(tr_busy[4]), 0);
        check("rst_mid_done@4", int'(tr_done[4]), 0);
        check("rst_mid_err@4",  int'(tr_err[4]), 0);
        check("rst_mid_rem@4",  int'({tr_rt[4], tr_rs[4]}), 0);
        check("rst_mid_n10",    n10, 1);
        check("rst_mid_busy",   busy_cnt, 3);
        check("rst_mid_done",   done_cnt, 0);
        issue(4'd0, 4'd5);
        capture(20, 0, 4'd0, 4'd0, 0);
        analyze(20);
        check("post_rst_n5",   n5, 1);
        check("post_rst_n10",  n10, 0);
        check("post_rst_done", first_done, 7);

        // Back-to-back: 10, then 05 one cycle after done.
        issue(4'd1, 4'd0);
        capture(25, 8, 4'd0, 4'd5, 0);
        analyze(25);
        check("b2b_c5@8",     int'(tr_c5[8]), 0);
        check("b2b_c5@9",     int'(tr_c5[9]), 1);
        check("b2b_busy@9",   int'(tr_busy[9]), 1);
        check("b2b_n10",      n10, 1);
        check("b2b_n5",       n5, 1);
        check("b2b_done_cnt", done_cnt, 2);
        check("b2b_done2",    int'(tr_done[15]), 1);

        // Start during the done cycle is dropped.
        issue(4'd1, 4'd0);
        capture(25, 7, 4'd0, 4'd5, 0);
        analyze(25);
        check("fin_ign_n5",   n5, 0);
        check("fin_ign_done", done_cnt, 1);
        check("fin_ign_busy", busy_cnt, 6);
        check("fin_ign_err",  err_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
